sram_arb: RTL and testbench
===========================

SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, word-address width of the shared RAM port.
REQ-002 SHALL have parameter LOCK_MAX, default 16, maximum number of consecutive cycles a lock may block a pending competing request.
REQ-003 SHALL have port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have, for each master x in {0,1}, port mx_req  input  1  request valid.
REQ-006 SHALL have, for each x, port mx_lock  input  1  request exclusive ownership after grant.
REQ-007 SHALL have, for each x, port mx_we  input  1  write (1) or read (0).
REQ-008 SHALL have, for each x, port mx_wem  input  4  byte write mask; bit i covers data bits [8i+7:8i].
REQ-009 SHALL have, for each x, port mx_addr  input  ADDR_W  word address.
REQ-010 SHALL have, for each x, port mx_wdata  input  32  write data.
REQ-011 SHALL have, for each x, port mx_gnt  output  1  request accepted this cycle (combinational).
REQ-012 SHALL have, for each x, port mx_rvalid  output  1  read data valid for master x.
REQ-013 SHALL have, for each x, port mx_rdata  output  32  read data, equal to ram_dout.
REQ-014 SHALL have ports ram_en (output, 1), ram_we (output, 1), ram_wem (output, 4), ram_addr (output, ADDR_W), ram_din (output, 32): the single RAM port command.
REQ-015 SHALL have port ram_dout  input  32  RAM read data, valid one cycle after a read command.

Function
REQ-016 SHALL grant at most one master per cycle; mx_gnt SHALL be 0 whenever mx_req is 0.
REQ-017 SHALL drive the granted master's we/wem/addr/wdata onto ram_we/ram_wem/ram_addr/ram_din and set ram_en=1 in the same cycle; with no grant, all ram_* outputs SHALL be 0.
REQ-018 SHALL, for a granted read, assert mx_rvalid for exactly one cycle on the following cycle; writes SHALL produce no rvalid.
REQ-019 SHALL implement state machine IDLE, LOCK0, LOCK1.
REQ-020 In IDLE with one requester, that master SHALL be granted.
REQ-021 In IDLE with both requesting, the master not granted most recently SHALL be granted (round-robin on a 1-bit last-grant pointer updated on every grant).
REQ-022 IDLE SHALL go to LOCKx when mx is granted with mx_lock=1.
REQ-023 In LOCKx only mx SHALL be granted; the other master SHALL receive no grant even if mx is idle.
REQ-024 LOCKx SHALL return to IDLE on the first cycle mx_lock=0, and arbitration in that same cycle SHALL follow IDLE rules.
REQ-025 SHALL count cycles in LOCKx during which the other master requests; the counter SHALL clear on entry to LOCKx and in any cycle the other master does not request.
REQ-026 When the counter reaches LOCK_MAX, the state SHALL go to IDLE, the other master SHALL be granted that cycle, and the pointer SHALL favour it; mx_lock SHALL be ignored for mx until mx_lock has been seen low once.
REQ-027 A grant with mx_lock=1 while already in LOCKx SHALL keep LOCKx without clearing the counter.
REQ-028 A request with mx_we=1 and mx_wem=0 SHALL still be granted and SHALL drive ram_we=1 with ram_wem=0, i.e. no byte written.

Reset
REQ-029 While rst_n=0 at a rising edge: state SHALL become IDLE, last-grant pointer SHALL become 1 (master 0 favoured), counter and lock-inhibit flags SHALL clear, and m0_rvalid/m1_rvalid SHALL be 0.
REQ-030 A read granted in the cycle in which reset is sampled SHALL NOT produce rvalid afterwards.
REQ-031 During reset, mx_gnt and ram_* SHALL remain combinational per REQ-016/017, with state treated as IDLE.

Verification
REQ-032 After reset, m0 and m1 read simultaneously for 4 cycles -> grants alternate m0, m1, m0, m1; each rvalid appears one cycle after its grant with rdata equal to the stored word.
REQ-033 m0 writes 0xAABBCCDD with wem=4'b0101 to address 5 over 0x11223344, then reads it -> rdata = 0x11BB33DD.
REQ-034 m1 granted with lock=1, holds lock for 3 cycles while m0 requests -> m0_gnt stays 0 until m1_lock drops, then m0 is granted in the same cycle.
REQ-035 With LOCK_MAX=16, m0 holds lock indefinitely while m1 requests continuously -> m1 is granted on the 16th blocked cycle, state is IDLE, and m0 cannot re-lock until m0_lock toggles low.
REQ-036 m0 read granted with rst_n=0 in that cycle -> m0_rvalid=0 next cycle; state IDLE; first contested grant after reset goes to m0.

Source files
------------

// File: rtl/sram_arb.sv
// sram_arb: two-master arbiter in front of a single-port word RAM.
// Round-robin between masters, with an optional lock that gives one master
// exclusive use of the RAM. The lock is bounded: a competing master that keeps
// requesting for LOCK_MAX cycles breaks it, and the former owner may not
// re-lock until it has dropped its lock request once.
module sram_arb #(
  parameter int ADDR_W   = 16,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // master 0
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_we,
  input  logic [3:0]        m0_wem,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  // master 1
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [3:0]        m1_wem,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  // shared RAM port
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_wem,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  state_e             state_q, state_d;
  logic               last_q, last_d;      // index of the most recently granted master
  logic [CNT_W-1:0]   cnt_q, cnt_d;        // cycles the non-owner has been held off
  logic [1:0]         inh_q, inh_d;        // per master: lock ignored until lock seen low
  logic [1:0]         rvalid_q, rvalid_d;

  logic [1:0] req, lock, we, gnt;
  state_e     state_eff;
  logic       owner;
  logic       arb_idle;

  assign req  = {m1_req, m0_req};
  assign lock = {m1_lock, m0_lock};
  assign we   = {m1_we, m0_we};

  // Arbitration and next-state: a held lock either keeps the owner exclusive or
  // is broken by the starvation counter; otherwise plain round-robin applies.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    inh_d    = inh_q & lock;
    gnt      = '0;
    arb_idle = 1'b1;

    // While reset is asserted the grant logic still runs, as if idle.
    state_eff = rst_n ? state_q : IDLE;
    owner     = (state_eff == LOCK1);

    if (state_eff != IDLE && lock[owner]) begin
      arb_idle = 1'b0;
      if (req[~owner] && cnt_q == CNT_W'(LOCK_MAX - 1)) begin
        // Starvation limit hit: hand this cycle to the waiting master.
        gnt[~owner]  = 1'b1;
        state_d      = IDLE;
        cnt_d        = '0;
        inh_d[owner] = 1'b1;
      end else begin
        gnt[owner] = req[owner];
        cnt_d      = req[~owner] ? cnt_q + CNT_W'(1) : '0;
      end
    end

    // Idle rules, also used in the cycle an owner releases its lock.
    if (arb_idle) begin
      state_d = IDLE;
      if (req == 2'b11) gnt[~last_q] = 1'b1;
      else              gnt          = req;
      if (gnt[0] && lock[0] && !inh_q[0]) begin
        state_d = LOCK0;
        cnt_d   = '0;
      end
      if (gnt[1] && lock[1] && !inh_q[1]) begin
        state_d = LOCK1;
        cnt_d   = '0;
      end
    end

    if (gnt[0]) last_d = 1'b0;
    if (gnt[1]) last_d = 1'b1;

    rvalid_d = gnt & ~we;
  end

  // State registers; reset also cancels a read granted in the reset cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      inh_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      inh_q    <= inh_d;
      rvalid_q <= rvalid_d;
    end
  end

  // RAM command mux: the granted master's fields, all zero without a grant.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_wem  = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt[0]) begin
      ram_en   = 1'b1;
      ram_we   = m0_we;
      ram_wem  = m0_wem;
      ram_addr = m0_addr;
      ram_din  = m0_wdata;
    end else if (gnt[1]) begin
      ram_en   = 1'b1;
      ram_we   = m1_we;
      ram_wem  = m1_wem;
      ram_addr = m1_addr;
      ram_din  = m1_wdata;
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_sram_arb.sv
// Testbench for sram_arb: directed scenarios followed by random traffic, with a
// reference arbiter model and a read-data scoreboard drained by a monitor.
module tb_sram_arb;

  localparam int ADDR_W   = 16;
  localparam int LOCK_MAX = 16;

  typedef struct packed {
    logic              req;
    logic              lock;
    logic              we;
    logic [3:0]        wem;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } mreq_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  mreq_t             s0, s1;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]       m0_rdata, m1_rdata;
  logic              ram_en, ram_we;
  logic [3:0]        ram_wem;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  sram_arb #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(s0.req), .m0_lock(s0.lock), .m0_we(s0.we), .m0_wem(s0.wem),
    .m0_addr(s0.addr), .m0_wdata(s0.wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(s1.req), .m1_lock(s1.lock), .m1_we(s1.we), .m1_wem(s1.wem),
    .m1_addr(s1.addr), .m1_wdata(s1.wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_pat(input logic [ADDR_W-1:0] a);
    return {a, ~a} ^ 32'h5A3C_96F0;
  endfunction

  // RAM attached to the DUT's port: one-cycle read latency, byte-masked writes.
  logic [31:0] env_mem [logic [ADDR_W-1:0]];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        logic [31:0] w;
        w = env_mem.exists(ram_addr) ? env_mem[ram_addr] : init_pat(ram_addr);
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) w[8*b +: 8] = ram_din[8*b +: 8];
        env_mem[ram_addr] = w;
      end else begin
        ram_dout <= env_mem.exists(ram_addr) ? env_mem[ram_addr] : init_pat(ram_addr);
      end
    end
  end

  // Reference model: owner of the lock (-1 none), last granted master,
  // cycles the other master has waited, and "may not re-lock" flags.
  int          m_owner = -1;
  int          m_last  = 1;
  int          m_blocked = 0;
  bit          m_norelock [2];
  logic [31:0] model_mem [logic [ADDR_W-1:0]];
  exp_t        exp_q0 [$];
  exp_t        exp_q1 [$];
  bit          mon_en = 1'b0;
  logic        g0_seen, g1_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, predict and compare grant/RAM command at
  // the falling edge, record expected read data, advance the model.
  task automatic cycle(input bit in_rst, input mreq_t a, input mreq_t b);
    mreq_t       s [2];
    int          g, o, p;
    bit          arb, tmo;
    logic [63:0] exp_ram, act_ram;
    logic [31:0] w;
    exp_t        e;
    rst_n = !in_rst;
    s0 = a;
    s1 = b;
    s[0] = a;
    s[1] = b;
    @(negedge clk);
    g = -1; arb = 1'b1; tmo = 1'b0; p = 0;
    o = in_rst ? -1 : m_owner;
    if (o >= 0) begin
      p = 1 - o;
      if (s[o].lock) begin
        arb = 1'b0;
        if (s[p].req && m_blocked == LOCK_MAX - 1) begin
          g = p;
          tmo = 1'b1;
        end else if (s[o].req) g = o;
      end
    end
    if (arb) begin
      if (s[0].req && s[1].req) g = 1 - m_last;
      else if (s[0].req)        g = 0;
      else if (s[1].req)        g = 1;
    end
    g0_seen = m0_gnt;
    g1_seen = m1_gnt;
    check("gnt", {62'd0, m1_gnt, m0_gnt}, {62'd0, g == 1, g == 0});
    exp_ram = '0;
    if (g >= 0) exp_ram = {10'd0, 1'b1, s[g].we, s[g].wem, s[g].addr, s[g].wdata};
    act_ram = {10'd0, ram_en, ram_we, ram_wem, ram_addr, ram_din};
    check("ram_cmd", act_ram, exp_ram);
    // Memory effect of the granted access.
    if (g >= 0) begin
      w = model_mem.exists(s[g].addr) ? model_mem[s[g].addr] : init_pat(s[g].addr);
      if (s[g].we) begin
        for (int i = 0; i < 4; i++)
          if (s[g].wem[i]) w[8*i +: 8] = s[g].wdata[8*i +: 8];
        model_mem[s[g].addr] = w;
      end else if (!in_rst) begin
        e.cyc = cyc;
        e.data = w;
        if (g == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
    end
    // Arbiter bookkeeping.
    if (in_rst) begin
      m_owner = -1; m_last = 1; m_blocked = 0;
      m_norelock[0] = 1'b0; m_norelock[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) if (!s[i].lock) m_norelock[i] = 1'b0;
      if (tmo) begin
        m_owner = -1;
        m_blocked = 0;
        m_norelock[o] = 1'b1;
      end else if (!arb) begin
        m_blocked = s[p].req ? m_blocked + 1 : 0;
      end else begin
        m_owner = -1;
        if (g >= 0 && s[g].lock && !m_norelock[g]) begin
          m_owner = g;
          m_blocked = 0;
        end
      end
      if (g >= 0) m_last = g;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: each falling edge, rvalid must match the scoreboard head that was
  // granted one cycle earlier, and rdata must equal the predicted word.
  task automatic rv_check(input int x, input logic rv, input logic [31:0] rd);
    bit   due;
    exp_t e;
    if (x == 0) due = exp_q0.size() > 0 && exp_q0[0].cyc == cyc - 1;
    else        due = exp_q1.size() > 0 && exp_q1[0].cyc == cyc - 1;
    if (due) begin
      if (x == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
    end
    vectors++;
    if (rv !== due) begin
      errors++;
      $display("FAIL rvalid%0d at cycle %0d: got %b want %b", x, cyc, rv, due);
    end else if (due && rd !== e.data) begin
      errors++;
      $display("FAIL rdata%0d at cycle %0d: got %h want %h", x, cyc, rd, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      rv_check(0, m0_rvalid, m0_rdata);
      rv_check(1, m1_rvalid, m1_rdata);
    end
  end

  function automatic mreq_t mk(input bit req, input bit lock, input bit we,
                               input logic [3:0] wem, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] wdata);
    mreq_t r;
    r.req = req; r.lock = lock; r.we = we; r.wem = wem; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  mreq_t idle;
  logic [1:0] want;

  initial begin
    idle = '0;
    s0 = '0;
    s1 = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, idle, idle);
    cycle(1, idle, idle);
    mon_en = 1'b1;
    check("reset_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);

    // Simultaneous reads alternate, m0 first.
    for (int k = 0; k < 4; k++) begin
      cycle(0, mk(1, 0, 0, 4'h0, 16'(10 + k), 0), mk(1, 0, 0, 4'h0, 16'(20 + k), 0));
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      check("rr_order", {62'd0, g1_seen, g0_seen}, {62'd0, want});
    end
    cycle(0, idle, idle);

    // Byte-masked write merge.
    cycle(0, mk(1, 0, 1, 4'hF, 16'd5, 32'h1122_3344), idle);
    cycle(0, mk(1, 0, 1, 4'b0101, 16'd5, 32'hAABB_CCDD), idle);
    cycle(0, mk(1, 0, 0, 4'h0, 16'd5, 0), idle);
    check("masked_write", {31'd0, m0_rvalid, m0_rdata}, {31'd0, 1'b1, 32'h11BB_33DD});

    // Write with an empty mask is granted but changes nothing.
    cycle(0, idle, mk(1, 0, 1, 4'h0, 16'd5, 32'hFFFF_FFFF));
    check("wem0_gnt", {63'd0, g1_seen}, 64'd1);
    cycle(0, idle, mk(1, 0, 0, 4'h0, 16'd5, 0));
    check("wem0_read", {31'd0, m1_rvalid, m1_rdata}, {31'd0, 1'b1, 32'h11BB_33DD});

    // m1 locks; m0 waits three cycles, then wins the release cycle.
    cycle(0, idle, mk(1, 1, 0, 4'h0, 16'd30, 0));
    for (int k = 0; k < 3; k++) begin
      cycle(0, mk(1, 0, 0, 4'h0, 16'd40, 0), mk(1, 1, 0, 4'h0, 16'(31 + k), 0));
      check("lock_blocks_m0", {62'd0, g1_seen, g0_seen}, 64'd2);
    end
    cycle(0, mk(1, 0, 0, 4'h0, 16'd40, 0), mk(1, 0, 0, 4'h0, 16'd34, 0));
    check("release_grants_m0", {62'd0, g1_seen, g0_seen}, 64'd1);
    cycle(0, idle, idle);

    // m0 holds its lock; m1 breaks it on the LOCK_MAX-th waiting cycle.
    cycle(0, mk(1, 1, 0, 4'h0, 16'd50, 0), idle);
    for (int k = 0; k < LOCK_MAX; k++) begin
      cycle(0, mk(1, 1, 0, 4'h0, 16'd51, 0), mk(1, 0, 0, 4'h0, 16'd60, 0));
      want = (k == LOCK_MAX - 1) ? 2'b10 : 2'b01;
      check("lock_timeout", {62'd0, g1_seen, g0_seen}, {62'd0, want});
    end
    cycle(0, mk(1, 1, 0, 4'h0, 16'd52, 0), idle);
    check("no_relock_gnt", {62'd0, g1_seen, g0_seen}, 64'd1);
    cycle(0, mk(0, 1, 0, 4'h0, 16'd0, 0), mk(1, 0, 0, 4'h0, 16'd61, 0));
    check("no_relock_m1_free", {62'd0, g1_seen, g0_seen}, 64'd2);
    cycle(0, mk(1, 0, 0, 4'h0, 16'd53, 0), idle);
    cycle(0, mk(1, 1, 0, 4'h0, 16'd54, 0), idle);
    cycle(0, mk(0, 1, 0, 4'h0, 16'd0, 0), mk(1, 0, 0, 4'h0, 16'd62, 0));
    check("relock_after_low", {62'd0, g1_seen, g0_seen}, 64'd0);
    cycle(0, idle, mk(1, 0, 0, 4'h0, 16'd62, 0));
    check("unlock_m1", {62'd0, g1_seen, g0_seen}, 64'd2);

    // Read granted during reset produces no rvalid; m0 wins first contest.
    cycle(1, mk(1, 0, 0, 4'h0, 16'd7, 0), idle);
    check("rst_read_gnt", {63'd0, g0_seen}, 64'd1);
    check("rst_read_no_rvalid", {63'd0, m0_rvalid}, 64'd0);
    cycle(0, mk(1, 0, 0, 4'h0, 16'd8, 0), mk(1, 0, 0, 4'h0, 16'd9, 0));
    check("post_rst_m0_first", {62'd0, g1_seen, g0_seen}, 64'd1);

    // Random traffic with sticky locks and occasional reset.
    begin
      bit l0 = 1'b0, l1 = 1'b0;
      for (int n = 0; n < 1500; n++) begin
        mreq_t a, b;
        if ($urandom_range(0, 7) == 0) l0 = !l0;
        if ($urandom_range(0, 7) == 0) l1 = !l1;
        a = mk($urandom_range(0, 3) != 0, l0, $urandom_range(0, 1) == 1,
               4'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), $urandom);
        b = mk($urandom_range(0, 3) != 0, l1, $urandom_range(0, 1) == 1,
               4'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), $urandom);
        cycle($urandom_range(0, 199) == 0, a, b);
      end
    end

    for (int k = 0; k < 3; k++) cycle(0, idle, idle);
    check("scoreboard_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
